// File: rtl/vmul_operand_prep_stage.sv
// Operand preparation ahead of the Vedic multiplier array: signed elements become magnitudes, each
// element's result sign is recorded, and the results are held in a 2-entry skid buffer.
module vmul_operand_prep_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PREC_W = 2,
    parameter int unsigned OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [OP_W-1:0]   opcode,
    input  logic [PREC_W-1:0] precision,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic [3:0]        neg_res,
    output logic [OP_W-1:0]   opcode_q,
    output logic [PREC_W-1:0] precision_q,
    output logic              prec_err
);

    localparam int unsigned LANES = XLEN / 8;

    localparam logic [OP_W-1:0]   OP_MUL    = OP_W'(0);
    localparam logic [OP_W-1:0]   OP_MULH   = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_MULHU  = OP_W'(2);
    localparam logic [PREC_W-1:0] PREC_8    = PREC_W'(0);
    localparam logic [PREC_W-1:0] PREC_16   = PREC_W'(1);
    localparam logic [PREC_W-1:0] PREC_32   = PREC_W'(2);
    localparam logic [PREC_W-1:0] PREC_RSVD = PREC_W'(3);

    typedef struct packed {
        logic [XLEN-1:0]   mag_a;
        logic [XLEN-1:0]   mag_b;
        logic [LANES-1:0]  neg;
        logic [OP_W-1:0]   op;
        logic [PREC_W-1:0] prec;
        logic              err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    entry_t            new_c;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              sgn_a, sgn_b;
    logic              push, pop;
    logic [PREC_W-1:0] prec_eff;

    function automatic logic [7:0] abs8(input logic [7:0] x, input logic s);
        return (s & x[7]) ? 8'(~x + 8'd1) : x;
    endfunction

    function automatic logic [15:0] abs16(input logic [15:0] x, input logic s);
        return (s & x[15]) ? 16'(~x + 16'd1) : x;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic s);
        return (s & x[31]) ? 32'(~x + 32'd1) : x;
    endfunction

    assign sgn_a    = (opcode != OP_MULHU);
    assign sgn_b    = (opcode == OP_MUL) || (opcode == OP_MULH);
    assign prec_eff = (precision == PREC_RSVD) ? PREC_32 : precision;
    assign push     = in_valid & in_ready_q;
    assign pop      = out_valid_q & out_ready;

    // Per-element magnitude and result sign; a zero operand forces a positive result.
    always_comb begin
        new_c      = '0;
        new_c.op   = opcode;
        new_c.prec = prec_eff;
        new_c.err  = (precision == PREC_RSVD);
        case (prec_eff)
            PREC_8: begin
                for (int i = 0; i < 4; i++) begin
                    new_c.mag_a[8*i +: 8] = abs8(operand_a[8*i +: 8], sgn_a);
                    new_c.mag_b[8*i +: 8] = abs8(operand_b[8*i +: 8], sgn_b);
                    new_c.neg[i] = ((sgn_a & operand_a[8*i+7]) ^ (sgn_b & operand_b[8*i+7]))
                                   & (|operand_a[8*i +: 8]) & (|operand_b[8*i +: 8]);
                end
            end
            PREC_16: begin
                for (int j = 0; j < 2; j++) begin
                    new_c.mag_a[16*j +: 16] = abs16(operand_a[16*j +: 16], sgn_a);
                    new_c.mag_b[16*j +: 16] = abs16(operand_b[16*j +: 16], sgn_b);
                    new_c.neg[2*j +: 2] = {2{((sgn_a & operand_a[16*j+15]) ^ (sgn_b & operand_b[16*j+15]))
                                             & (|operand_a[16*j +: 16]) & (|operand_b[16*j +: 16])}};
                end
            end
            default: begin
                new_c.mag_a = abs32(operand_a, sgn_a);
                new_c.mag_b = abs32(operand_b, sgn_b);
                new_c.neg   = {LANES{((sgn_a & operand_a[31]) ^ (sgn_b & operand_b[31]))
                                     & (|operand_a) & (|operand_b)}};
            end
        endcase
    end

    // Occupancy FSM: head feeds the array, skid catches the entry accepted while the head stalls.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        head_d  = new_c;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = new_c;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = new_c;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign in_ready    = in_ready_q;
    assign mag_a       = head_q.mag_a;
    assign mag_b       = head_q.mag_b;
    assign neg_res     = head_q.neg;
    assign opcode_q    = head_q.op;
    assign precision_q = head_q.prec;
    assign prec_err    = head_q.err;

endmodule
